aud_dac_serializer: RTL and testbench

- Downstream consumer of the APU sample path. Accepts 16-bit mono audio samples from the SPU/output buffer through a valid/ready handshake and holds them in a small FIFO.
- Generates the codec bit clock (BCLK) and left/right clock (LRCK) from the system clock.
- Serializes each sample MSB-first onto DAC_DAT in left-justified format, sending the same sample on the left and right channels.

---
 rtl/aud_dac_serializer.sv | 131 +++++++++++++
 tb/tb_aud_dac_serializer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/aud_dac_serializer.sv
// Audio DAC serializer: buffers 16-bit mono samples in a small FIFO and emits
// them MSB-first in left-justified format, duplicated onto both LRCK channels.
module aud_dac_serializer #(
  parameter int BCLK_DIV = 4,
  parameter int DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [15:0]            smpl_in,
  input  logic                   smpl_vld,
  output logic                   smpl_rdy,
  output logic                   BCLK,
  output logic                   LRCK,
  output logic                   DAC_DAT,
  output logic                   underrun,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(BCLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   sample_q, sample_d;
  logic          bclk_q, bclk_d;
  logic          lrck_q, lrck_d;
  logic          dac_q, dac_d;
  logic          underrun_q, underrun_d;
  logic          push, pop;

  assign smpl_rdy = (fifo_cnt_q < CW'(DEPTH));
  assign push     = smpl_vld && smpl_rdy;

  // NOTE: all comb outputs get a default first so no path leaves one unassigned (no latches).
  always_comb begin
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    bit_cnt_d  = bit_cnt_q;
    lrck_d     = lrck_q;
    dac_d      = dac_q;
    sample_d   = sample_q;
    underrun_d = 1'b0;
    pop        = 1'b0;

    if (!en) begin
      // Parking bit_cnt at 31 makes the first falling BCLK after enable a frame start.
      div_cnt_d = '0;
      bclk_d    = 1'b0;
      lrck_d    = 1'b0;
      dac_d     = 1'b0;
      bit_cnt_d = 5'd31;
      sample_d  = '0;
    end else if (div_cnt_q == DIV_MAX) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
      if (bclk_q) begin
        // NOTE: blocking assignments here let later lines use the freshly computed bit_cnt_d/sample_d.
        bit_cnt_d = bit_cnt_q + 5'd1;
        lrck_d    = bit_cnt_d[4];
        if (bit_cnt_d == 5'd0) begin
          if (fifo_cnt_q != '0) begin
            pop      = 1'b1;
            sample_d = mem[rd_ptr_q];
          end else begin
            sample_d   = '0;
            underrun_d = 1'b1;
          end
        end
        dac_d = sample_d[4'd15 - bit_cnt_d[3:0]];
      end
    end else begin
      div_cnt_d = div_cnt_q + DW'(1);
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      sample_q   <= '0;
      bclk_q     <= 1'b0;
      lrck_q     <= 1'b0;
      dac_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sample_q   <= sample_d;
      bclk_q     <= bclk_d;
      lrck_q     <= lrck_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers and count discards its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= smpl_in;
  end

  assign BCLK     = bclk_q;
  assign LRCK     = lrck_q;
  assign DAC_DAT  = dac_q;
  assign underrun = underrun_q;
  assign fifo_cnt = fifo_cnt_q;

endmodule

// File: tb/tb_aud_dac_serializer.sv
// Randomized bench for aud_dac_serializer; expectations come from an
// edge-count/queue model of the serial frame format.
module tb_aud_dac_serializer;

  localparam int BD    = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] smpl_in = '0;
  logic        smpl_vld = 1'b0;
  logic        smpl_rdy, BCLK, LRCK, DAC_DAT, underrun;
  logic [$clog2(DEPTH):0] fifo_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  aud_dac_serializer #(.BCLK_DIV(BD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .smpl_in(smpl_in), .smpl_vld(smpl_vld),
    .smpl_rdy(smpl_rdy), .BCLK(BCLK), .LRCK(LRCK), .DAC_DAT(DAC_DAT),
    .underrun(underrun), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model: edges counted since enable; BCLK falls every 2*BD edges and the
  // k-th fall carries bit (k-1) mod 32 of frame (k-1)/32.
  logic [15:0] q[$];
  logic [15:0] cur;
  logic        m_bclk, m_lrck, m_dac, m_und;
  int          e, old, k, b;
  bit          do_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      e = 0; cur = '0;
      m_bclk = 0; m_lrck = 0; m_dac = 0; m_und = 0;
    end else begin
      old     = q.size();
      do_push = smpl_vld && (old < DEPTH);
      m_und   = 0;
      if (!en) begin
        e = 0; m_bclk = 0; m_lrck = 0; m_dac = 0;
      end else begin
        e++;
        m_bclk = ((e / BD) % 2) == 1;
        if (e % (2 * BD) == 0) begin
          k = e / (2 * BD);
          b = (k - 1) % 32;
          if (b == 0) begin
            if (old > 0) cur = q.pop_front();
            else begin cur = '0; m_und = 1; end
          end
          m_lrck = (b >= 16);
          m_dac  = cur[15 - (b % 16)];
        end
      end
      if (do_push) q.push_back(smpl_in);
    end
  end

  always @(negedge clk) begin
    check("bclk",     32'(BCLK),     32'(m_bclk));
    check("lrck",     32'(LRCK),     32'(m_lrck));
    check("dac_dat",  32'(DAC_DAT),  32'(m_dac));
    check("underrun", 32'(underrun), 32'(m_und));
    check("fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
    check("smpl_rdy", 32'(smpl_rdy), 32'(q.size() < DEPTH));
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_one(input logic [15:0] d);
    smpl_in = d; smpl_vld = 1'b1;
    tick(1);
    smpl_vld = 1'b0;
  endtask

  initial begin
    // Reset and idle with en low
    tick(10);
    check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("rst_rdy",      32'(smpl_rdy), 32'd1);
    rst_n = 1'b1;
    tick(5);

    // Single known sample plus a trailing underrun frame
    push_one(16'hA5C3);
    en = 1'b1;
    tick(64 * BD * 2 + 20);
    en = 1'b0;
    tick(3);

    // Fill and backpressure: six back-to-back offers, four accepted
    for (int i = 1; i <= 6; i++) push_one(16'(i * 16'h1111));
    check("full_cnt", 32'(fifo_cnt), 32'd4);
    check("full_rdy", 32'(smpl_rdy), 32'd0);
    en = 1'b1;
    tick(64 * BD * 5 + 10);
    en = 1'b0;
    tick(2);

    // Push coinciding with the frame-start pop
    push_one(16'($urandom));
    push_one(16'($urandom));
    en = 1'b1;
    tick(2 * BD - 1);
    smpl_in = 16'($urandom); smpl_vld = 1'b1;
    tick(1);
    smpl_vld = 1'b0;
    check("pushpop_cnt", 32'(fifo_cnt), 32'd2);

    // Drop enable mid-frame (around bit 7), then resume
    tick(2 * BD * 7);
    en = 1'b0;
    tick(1);
    check("dis_bclk", 32'(BCLK), 32'd0);
    check("dis_cnt",  32'(fifo_cnt), 32'd2);
    tick(4);
    en = 1'b1;

    // Random traffic with occasional enable glitches
    for (int i = 0; i < 4000; i++) begin
      smpl_in  = 16'($urandom);
      smpl_vld = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 1499) == 0) en = ~en;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      tick(1);
    end
    smpl_vld = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) push_one(16'($urandom));
    tick(64 * BD + 37);

    // Asynchronous reset mid-frame
    #2 rst_n = 1'b0;
    #1;
    check("arst_bclk", 32'(BCLK),     32'd0);
    check("arst_lrck", 32'(LRCK),     32'd0);
    check("arst_dac",  32'(DAC_DAT),  32'd0);
    check("arst_cnt",  32'(fifo_cnt), 32'd0);
    check("arst_rdy",  32'(smpl_rdy), 32'd1);
    en = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
